// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues single-outstanding reads to
// instruction memory, buffers returned words in a small FIFO and presents the
// head instruction with its RV32I register fields to the decode stage.
// Supports redirect (flush + restart) and downstream stall.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rd_we
);

  localparam int unsigned      PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;

  logic [31:0]      r_buf_pc    [BUF_DEPTH];
  logic [31:0]      r_buf_instr [BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic [CNT_W-1:0] w_count_after_pop;
  logic             w_op_writes;

  assign instr_valid       = (r_count != '0);
  assign w_pop             = instr_valid & ~stall;
  assign w_count_after_pop = r_count - CNT_W'(w_pop);
  assign imem_addr         = r_pc;

  // Next-state, next-PC and push/flush decisions; redirect overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    imem_req    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count_after_pop < DEPTH_C) w_state_nxt = REQ;
      end
      REQ: begin
        imem_req    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          w_push      = 1'b1;
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = ((w_count_after_pop + CNT_W'(1)) < DEPTH_C) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (imem_rvalid) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
    // A request still in flight after the redirect must have its response dropped.
    if (redirect_valid) begin
      w_flush  = 1'b1;
      w_push   = 1'b0;
      w_pc_nxt = redirect_pc;
      if ((r_state == REQ) || ((r_state == WAIT || r_state == DISCARD) && !imem_rvalid))
        w_state_nxt = DISCARD;
      else
        w_state_nxt = REQ;
    end
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // FIFO pointers and occupancy; a flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (reset || w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      r_count <= w_count_after_pop + CNT_W'(w_push);
    end
  end

  // FIFO storage: captures the fetched word together with the PC it came from.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_pc;
      r_buf_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  // Head presentation and decode fields; everything reads zero when empty.
  always_comb begin
    instr    = instr_valid ? r_buf_instr[r_rd_ptr] : '0;
    instr_pc = instr_valid ? r_buf_pc[r_rd_ptr]    : '0;
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    rd       = instr[11:7];
    case (instr[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0010011, 7'b0110011: w_op_writes = 1'b1;
      default:                            w_op_writes = 1'b0;
    endcase
    rd_we = w_op_writes & (rd != '0);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by a randomized
// run, all checked against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_we;

  instr_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  // Reference model: ordered stream of accepted fetches plus one memory slot.
  entry_t      model_q [$];
  logic [31:0] model_pc;
  bit          mem_busy;
  bit          mem_discard;
  bit          exp_req;
  int unsigned mem_wait;
  int unsigned lat_min, lat_max;
  logic [31:0] force_q [$];
  logic [31:0] popped [$];
  logic [31:0] req_log [$];
  bit          last_req;
  logic [31:0] last_req_addr;
  logic [6:0]  ops [7] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rd_we(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && (w[11:7] != 5'd0);
  endfunction

  task automatic check_outputs();
    entry_t h;
    if (model_q.size() == 0) begin
      h = '0;
      chk("instr_valid", instr_valid, 0);
    end else begin
      h = model_q[0];
      chk("instr_valid", instr_valid, 1);
    end
    chk("instr",    instr,    h.word);
    chk("instr_pc", instr_pc, h.pc);
    chk("rs1",      rs1,      h.word[19:15]);
    chk("rs2",      rs2,      h.word[24:20]);
    chk("rd",       rd,       h.word[11:7]);
    chk("rd_we",    rd_we,    exp_rd_we(h.word));
  endtask

  // One clock cycle: drive inputs, check at negedge, advance the model.
  task automatic tick(input bit redir, input logic [31:0] rpc, input bit stl);
    bit          rv;
    bit          pop;
    logic [31:0] word;
    entry_t      e;
    rv = 1'b0;
    if (mem_busy) begin
      if (mem_wait == 0) rv = 1'b1;
      else mem_wait--;
    end
    word = $urandom;
    if ($urandom_range(0, 1) == 1) word[6:0] = ops[$urandom_range(0, 6)];
    if (rv && force_q.size() > 0) word = force_q.pop_front();
    imem_rvalid    = rv;
    imem_rdata     = word;
    redirect_valid = redir;
    redirect_pc    = rpc;
    stall          = stl;
    @(negedge clk);
    check_outputs();
    chk("imem_req", imem_req, exp_req);
    last_req      = imem_req;
    last_req_addr = imem_addr;
    if (imem_req) begin
      req_log.push_back(imem_addr);
      chk("imem_addr", imem_addr, model_pc);
      chk("req_room", model_q.size() < DEPTH, 1);
    end
    if (instr_valid && !stl && !redir) popped.push_back(instr_pc);
    pop = (model_q.size() != 0) && !stl;
    if (redir) begin
      model_q.delete();
      model_pc = rpc;
      if (rv) begin
        mem_busy    = 1'b0;
        mem_discard = 1'b0;
      end else if (mem_busy) begin
        mem_discard = 1'b1;
      end
    end else begin
      if (pop) void'(model_q.pop_front());
      if (rv) begin
        mem_busy = 1'b0;
        if (!mem_discard) begin
          e.pc   = model_pc;
          e.word = word;
          model_q.push_back(e);
          model_pc = model_pc + 32'd4;
        end
        mem_discard = 1'b0;
      end
    end
    if (imem_req) begin
      mem_busy    = 1'b1;
      mem_wait    = $urandom_range(lat_max - 1, lat_min - 1);
      mem_discard = redir;
    end
    exp_req = !mem_busy && (model_q.size() < DEPTH);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_imem_req",    imem_req,    0);
    chk("rst_imem_addr",   imem_addr,   RST_PC);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr",       instr,       0);
    chk("rst_instr_pc",    instr_pc,    0);
    chk("rst_fields",      {rs1, rs2, rd}, 0);
    chk("rst_rd_we",       rd_we,       0);
    model_q.delete();
    popped.delete();
    req_log.delete();
    model_pc    = RST_PC;
    mem_busy    = 1'b0;
    mem_discard = 1'b0;
    exp_req     = 1'b0;
    reset       = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] r;
    bit redir;
    reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    checks = 0; errors = 0; lat_min = 1; lat_max = 1;

    // Sequential fetch with single-cycle memory and no stall.
    do_reset();
    tick(0, 0, 0); chk("t1_req_c1", last_req, 0);
    tick(0, 0, 0); chk("t1_req_c2", last_req, 1);
    for (int i = 0; i < 10; i++) tick(0, 0, 0);
    chk("t1_req0", req_log[0], 32'h0);
    chk("t1_req1", req_log[1], 32'h4);
    chk("t1_req2", req_log[2], 32'h8);
    chk("t1_pop0", popped[0], 32'h0);
    chk("t1_pop1", popped[1], 32'h4);
    chk("t1_pop2", popped[2], 32'h8);

    // Stall fills the buffer then fetching pauses; release resumes at 0x8.
    do_reset();
    for (int i = 0; i < 8; i++) tick(0, 0, 1);
    chk("t2_reqs", req_log.size(), 2);
    chk("t2_valid", instr_valid, 1);
    req_log.delete();
    popped.delete();
    for (int i = 0; i < 10; i++) tick(0, 0, 0);
    chk("t2_resume", req_log[0], 32'h8);
    chk("t2_pop0", popped[0], 32'h0);
    chk("t2_pop1", popped[1], 32'h4);

    // Redirect while waiting; late response must be dropped.
    do_reset();
    lat_min = 3; lat_max = 3;
    n = 0;
    while (!last_req && n < 10) begin tick(0, 0, 0); n++; end
    chk("t3_found_req", last_req, 1);
    tick(1, 32'h100, 0);
    req_log.delete();
    popped.delete();
    for (int i = 0; i < 12; i++) tick(0, 0, 0);
    chk("t3_req_addr", req_log[0], 32'h100);
    chk("t3_first_pc", popped[0], 32'h100);

    // Register-field decode and rd write-enable.
    do_reset();
    lat_min = 1; lat_max = 1;
    force_q.push_back(32'h00B50533);
    force_q.push_back(32'h00B52023);
    force_q.push_back(32'h00000013);
    for (int i = 0; i < 6; i++) tick(0, 0, 1);
    chk("t4_instr_a", instr, 32'h00B50533);
    chk("t4_rs1", rs1, 10);
    chk("t4_rs2", rs2, 11);
    chk("t4_rd", rd, 10);
    chk("t4_rdwe_a", rd_we, 1);
    tick(0, 0, 0);
    chk("t4_instr_b", instr, 32'h00B52023);
    chk("t4_rdwe_b", rd_we, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 10 && !instr_valid; i++) tick(0, 0, 1);
    chk("t4_instr_c", instr, 32'h00000013);
    chk("t4_rdwe_c", rd_we, 0);

    // Reset while a fetch is outstanding with data buffered.
    do_reset();
    for (int i = 0; i < 6; i++) tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 1);
    chk("t5_req_was_issued", last_req, 1);
    chk("t5_buffered", instr_valid, 1);
    do_reset();
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("t5_refetch", last_req_addr, RST_PC);
    chk("t5_refetch_req", last_req, 1);

    // Redirect coinciding with the response under stall.
    do_reset();
    for (int i = 0; i < 10 && req_log.size() < 2; i++) tick(0, 0, 1);
    chk("t6_two_reqs", req_log.size(), 2);
    tick(1, 32'h200, 1);
    chk("t6_empty", instr_valid, 0);
    tick(0, 0, 1);
    chk("t6_req", last_req, 1);
    chk("t6_addr", last_req_addr, 32'h200);

    // PC wraps modulo 2^32.
    do_reset();
    tick(1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0);
    chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
    chk("wrap_req1", req_log[1], 32'h0);

    // Randomized traffic: stall, redirects, variable memory latency.
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      redir = ($urandom_range(0, 19) == 0);
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       r = 32'hFFFF_FFF8;
        1:       r = 32'hFFFF_FFFC;
        default: r = r & 32'hFFFF_FFFC;
      endcase
      tick(redir, r, ($urandom_range(0, 9) < 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
